// File: rtl/syn_datamem_responder_pkg.sv
// rtl/syn_datamem_responder_pkg.sv - data-memory op codes, widths and FSM state type
package syn_datamem_responder_pkg;

  localparam int DM_OP_BIT   = 3;
  localparam int DM_ADDR_BIT = 12;

  localparam logic [DM_OP_BIT-1:0] DM_OP_W  = 3'd0;
  localparam logic [DM_OP_BIT-1:0] DM_OP_HU = 3'd1;
  localparam logic [DM_OP_BIT-1:0] DM_OP_H  = 3'd2;
  localparam logic [DM_OP_BIT-1:0] DM_OP_BU = 3'd3;
  localparam logic [DM_OP_BIT-1:0] DM_OP_B  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

endpackage

// File: rtl/syn_datamem_responder_if.sv
// rtl/syn_datamem_responder_if.sv - request/response channels between DM stage and responder
interface syn_datamem_responder_if
  import syn_datamem_responder_pkg::*;
#(
  parameter int AddrBit = DM_ADDR_BIT
);
  logic                 req_valid;
  logic                 req_ready;
  logic [AddrBit-1:0]   req_addr;
  logic                 req_w_en;
  logic [DM_OP_BIT-1:0] req_op;
  logic [31:0]          req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_rdata;
  logic                 resp_err;

  modport master (
    output req_valid, req_addr, req_w_en, req_op, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_w_en, req_op, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/syn_datamem_responder_lane.sv
// rtl/syn_datamem_responder_lane.sv - byte-lane merge, extraction and alignment check
module cmb_dm_lane_unit
  import syn_datamem_responder_pkg::*;
(
  input  logic [DM_OP_BIT-1:0] op_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [31:0]          rword_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          wword_o,
  output logic [3:0]           be_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o
);
  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    wword_o = rword_i;
    be_o    = 4'b0000;
    rdata_o = 32'd0;
    err_o   = 1'b0;
    half    = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    byte_v  = rword_i[8*addr_lo_i +: 8];
    case (op_i)
      DM_OP_W: begin
        err_o   = (addr_lo_i != 2'd0);
        be_o    = 4'b1111;
        wword_o = wdata_i;
        rdata_o = rword_i;
      end
      DM_OP_H, DM_OP_HU: begin
        err_o   = addr_lo_i[0];
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o = addr_lo_i[1] ? {wdata_i[15:0], rword_i[15:0]} : {rword_i[31:16], wdata_i[15:0]};
        rdata_o = (op_i == DM_OP_H) ? {{16{half[15]}}, half} : {16'd0, half};
      end
      DM_OP_B, DM_OP_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wword_o[8*addr_lo_i +: 8] = wdata_i[7:0];
        rdata_o = (op_i == DM_OP_B) ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
      end
      default: err_o = 1'b1;
    endcase
    // A faulting access must neither write nor return data.
    if (err_o) begin
      be_o    = 4'b0000;
      rdata_o = 32'd0;
    end
  end
endmodule

// File: rtl/syn_datamem_responder.sv
// rtl/syn_datamem_responder.sv - data-memory responder with configurable wait states
module syn_datamem_responder
  import syn_datamem_responder_pkg::*;
#(
  parameter int AddrBit    = DM_ADDR_BIT,
  parameter int WaitCycles = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  syn_datamem_responder_if.slave dm,
  input  logic [AddrBit-3:0]   addr_dbg,
  output logic [31:0]          data_dbg
);
  localparam int Words = 1 << (AddrBit - 2);

  logic [31:0] mem_q [Words];

  dm_state_e            state_q;
  logic [3:0]           cnt_q;
  logic [AddrBit-1:0]   addr_q;
  logic                 w_en_q;
  logic [DM_OP_BIT-1:0] op_q;
  logic [31:0]          wdata_q;
  logic                 req_ready_q;
  logic                 resp_valid_q;
  logic [31:0]          rdata_q;
  logic                 err_q;

  logic [AddrBit-1:0]   acc_addr_d;
  logic                 acc_w_en_d;
  logic [DM_OP_BIT-1:0] acc_op_d;
  logic [31:0]          acc_wdata_d;
  logic                 commit_d;
  logic [31:0]          lane_wword;
  logic [3:0]           lane_be;
  logic [31:0]          lane_rdata;
  logic                 lane_err;

  // With no wait states the access commits on the accepting edge, straight from the request.
  always_comb begin
    acc_addr_d  = addr_q;
    acc_w_en_d  = w_en_q;
    acc_op_d    = op_q;
    acc_wdata_d = wdata_q;
    commit_d    = 1'b0;
    if (state_q == ST_IDLE) begin
      acc_addr_d  = dm.req_addr;
      acc_w_en_d  = dm.req_w_en;
      acc_op_d    = dm.req_op;
      acc_wdata_d = dm.req_wdata;
      commit_d    = dm.req_valid && (WaitCycles == 0);
    end else if (state_q == ST_WAIT) begin
      commit_d    = (cnt_q == 4'd0);
    end
  end

  cmb_dm_lane_unit u_lane (
    .op_i      (acc_op_d),
    .addr_lo_i (acc_addr_d[1:0]),
    .rword_i   (mem_q[acc_addr_d[AddrBit-1:2]]),
    .wdata_i   (acc_wdata_d),
    .wword_o   (lane_wword),
    .be_o      (lane_be),
    .rdata_o   (lane_rdata),
    .err_o     (lane_err)
  );

  always_ff @(posedge clk) begin
    if (!rst && commit_d && acc_w_en_d) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) mem_q[acc_addr_d[AddrBit-1:2]][8*i +: 8] <= lane_wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      w_en_q       <= 1'b0;
      op_q         <= '0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dm.req_valid) begin
            addr_q      <= dm.req_addr;
            w_en_q      <= dm.req_w_en;
            op_q        <= dm.req_op;
            wdata_q     <= dm.req_wdata;
            req_ready_q <= 1'b0;
            if (WaitCycles == 0) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              rdata_q      <= acc_w_en_d ? 32'd0 : lane_rdata;
              err_q        <= lane_err;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= 4'(WaitCycles - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= acc_w_en_d ? 32'd0 : lane_rdata;
            err_q        <= lane_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (dm.resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign dm.req_ready  = req_ready_q;
  assign dm.resp_valid = resp_valid_q;
  assign dm.resp_rdata = rdata_q;
  assign dm.resp_err   = err_q;
  assign data_dbg      = mem_q[addr_dbg];

endmodule

// File: tb/tb_syn_datamem_responder.sv
// tb/tb_syn_datamem_responder.sv - randomized bench against a byte-lane memory model
module tb_syn_datamem_responder;
  import syn_datamem_responder_pkg::*;

  localparam int AW = 12;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  addr_dbg = '0;
  logic [31:0] data_dbg;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [1024];

  syn_datamem_responder_if #(.AddrBit(AW)) bus ();

  syn_datamem_responder #(.AddrBit(AW), .WaitCycles(WC)) dut (
    .clk      (clk),
    .rst      (rst),
    .dm       (bus),
    .addr_dbg (addr_dbg),
    .data_dbg (data_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: size/sign rules applied with masks and shifts on a word array.
  task automatic model(input logic w, input logic [2:0] op, input logic [11:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int lane;
    logic [31:0] word, mask, v;
    lane = int'(a[1:0]);
    word = model_mem[a[11:2]];
    rd = 32'd0;
    if (op == DM_OP_W)                         e = (lane != 0);
    else if (op == DM_OP_H || op == DM_OP_HU)  e = (lane % 2 != 0);
    else if (op == DM_OP_B || op == DM_OP_BU)  e = 1'b0;
    else                                       e = 1'b1;
    if (!e) begin
      if (op == DM_OP_W) mask = 32'hFFFF_FFFF;
      else if (op == DM_OP_H || op == DM_OP_HU) mask = 32'h0000_FFFF;
      else mask = 32'h0000_00FF;
      if (w) begin
        model_mem[a[11:2]] = (word & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
      end else begin
        v = (word >> (8 * lane)) & mask;
        if (op == DM_OP_H && v[15]) v = v | 32'hFFFF_0000;
        if (op == DM_OP_B && v[7])  v = v | 32'hFFFF_FF00;
        rd = v;
      end
    end
  endtask

  task automatic do_req(input logic w, input logic [2:0] op, input logic [11:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic e);
    int lat;
    int guard;
    logic [31:0] exp_rd;
    logic exp_e;
    model(w, op, a, wd, exp_rd, exp_e);
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (bus.req_ready !== 1'b1) check("req_ready_timeout", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_w_en  = w;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_w_en  = 1'($urandom);
    bus.req_op    = 3'($urandom);
    bus.req_addr  = 12'($urandom);
    bus.req_wdata = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.req_ready && bus.resp_valid) check("ready_valid_overlap", 1, 0);
    end while (bus.resp_valid !== 1'b1 && lat < 40);
    check("latency", lat, WC + 1);
    check("req_ready_in_resp", bus.req_ready, 0);
    rd = bus.resp_rdata;
    e  = bus.resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.resp_valid, 1);
      check("hold_rdata", bus.resp_rdata, rd);
      check("hold_err", bus.resp_err, e);
      check("hold_req_ready", bus.req_ready, 0);
    end
    check("rdata", rd, exp_rd);
    check("err", e, exp_e);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    check("req_ready_after", bus.req_ready, 1);
    check("resp_valid_after", bus.resp_valid, 0);
    addr_dbg = a[11:2];
    #1;
    check("dbg_word", data_dbg, model_mem[a[11:2]]);
  endtask

  logic [31:0] rd;
  logic        e;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_w_en   = 1'b0;
    bus.req_op     = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_rdata", bus.resp_rdata, 0);
    check("rst_err", bus.resp_err, 0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) do_req(1'b1, DM_OP_W, 12'(i * 4), $urandom, 0, rd, e);

    do_req(1'b1, DM_OP_W, 12'h010, 32'hDEADBEEF, 0, rd, e);
    do_req(1'b0, DM_OP_W, 12'h010, 32'h0, 0, rd, e);
    check("t1_load_w", rd, 32'hDEADBEEF);

    do_req(1'b1, DM_OP_W, 12'h020, 32'h80FF7F01, 0, rd, e);
    do_req(1'b0, DM_OP_B, 12'h023, 32'h0, 0, rd, e);
    check("t2_b", rd, 32'hFFFFFF80);
    do_req(1'b0, DM_OP_BU, 12'h023, 32'h0, 0, rd, e);
    check("t2_bu", rd, 32'h00000080);
    do_req(1'b0, DM_OP_H, 12'h022, 32'h0, 0, rd, e);
    check("t2_h", rd, 32'hFFFF80FF);
    do_req(1'b0, DM_OP_HU, 12'h020, 32'h0, 0, rd, e);
    check("t2_hu", rd, 32'h00007F01);

    do_req(1'b1, DM_OP_W, 12'h020, 32'h11223344, 0, rd, e);
    do_req(1'b1, DM_OP_B, 12'h021, 32'h000000AB, 0, rd, e);
    addr_dbg = 10'd8;
    #1;
    check("t3_partial", data_dbg, 32'h1122AB44);

    do_req(1'b1, DM_OP_W, 12'h030, 32'hCAFEF00D, 0, rd, e);
    do_req(1'b1, DM_OP_W, 12'h032, 32'h12345678, 0, rd, e);
    check("t4_w_err", e, 1);
    check("t4_w_rdata", rd, 0);
    addr_dbg = 10'd12;
    #1;
    check("t4_unchanged", data_dbg, 32'hCAFEF00D);
    do_req(1'b0, DM_OP_H, 12'h031, 32'h0, 0, rd, e);
    check("t4_h_err", e, 1);

    do_req(1'b0, DM_OP_W, 12'h030, 32'h0, 5, rd, e);
    check("t5_bp_rdata", rd, 32'hCAFEF00D);

    do_req(1'b1, DM_OP_W, 12'h040, 32'h00000005, 0, rd, e);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_w_en  = 1'b1;
    bus.req_op    = DM_OP_W;
    bus.req_addr  = 12'h040;
    bus.req_wdata = 32'hFFFF0000;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_req_ready", bus.req_ready, 1);
    check("t6_resp_valid", bus.resp_valid, 0);
    check("t6_rdata", bus.resp_rdata, 0);
    check("t6_err", bus.resp_err, 0);
    addr_dbg = 10'd16;
    #1;
    check("t6_word_kept", data_dbg, 32'h00000005);

    for (int i = 0; i < 200; i++) begin
      do_req(1'($urandom), 3'($urandom_range(0, 7)), 12'($urandom_range(0, 127)),
             $urandom, int'($urandom_range(0, 3)), rd, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
